// File: rtl/cpu_fetch.sv
// cpu_fetch: program-memory fetch, 3-word instruction assembly and buffered hand-off to execute
module cpu_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] ins_opcode,
  output logic [15:0] ins_par1,
  output logic [15:0] ins_par2,
  output logic [15:0] ins_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] fetch_pc
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {W0, W1, W2} state_t;
  state_t          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [1:0]      iss_q, iss_d;
  logic            inflight_q, inflight_d;
  logic [15:0]     raddr_q, raddr_d;
  logic [15:0]     stg_op_q, stg_op_d, stg_p1_q, stg_p1_d, stg_pc_q, stg_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [15:0]     op_q [DEPTH], op_d [DEPTH];
  logic [15:0]     p1_q [DEPTH], p1_d [DEPTH];
  logic [15:0]     p2_q [DEPTH], p2_d [DEPTH];
  logic [15:0]     pc_q [DEPTH], pc_d [DEPTH];
  logic            pending, cap, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ins_valid  = count_q != '0;
  assign ins_opcode = op_q[head_q];
  assign ins_par1   = p1_q[head_q];
  assign ins_par2   = p2_q[head_q];
  assign ins_pc     = pc_q[head_q];
  assign fetch_pc   = fetch_pc_q;

  // A buffer slot is reserved when word 0 is issued; the remaining words of that instruction always follow
  always_comb begin
    pending    = (state_q != W0) || inflight_q;
    mem_rd     = rst_n && !redirect && (iss_q != 2'd0 || int'(count_q) + int'(pending) < DEPTH);
    mem_addr   = mem_rd ? fetch_pc_q : 16'h0000;
    cap        = inflight_q && !redirect;
    push       = cap && state_q == W2;
    pop        = ins_valid && ins_ready;
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + 16'(mem_rd);
    iss_d      = redirect ? 2'd0 : !mem_rd ? iss_q : iss_q == 2'd2 ? 2'd0 : iss_q + 2'd1;
    inflight_d = mem_rd;
    raddr_d    = fetch_pc_q;
    stg_op_d   = cap && state_q == W0 ? mem_rdata : stg_op_q;
    stg_pc_d   = cap && state_q == W0 ? raddr_q : stg_pc_q;
    stg_p1_d   = cap && state_q == W1 ? mem_rdata : stg_p1_q;
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    head_d     = redirect ? '0 : pop ? nxt(head_q) : head_q;
    tail_d     = redirect ? '0 : push ? nxt(tail_q) : tail_q;
    state_d    = state_q;
    if (redirect) state_d = W0;
    else if (cap) begin
      case (state_q)
        W0:      state_d = W1;
        W1:      state_d = W2;
        default: state_d = W0;
      endcase
    end
    op_d = op_q;
    p1_d = p1_q;
    p2_d = p2_q;
    pc_d = pc_q;
    if (push) begin
      op_d[tail_q] = stg_op_q;
      p1_d[tail_q] = stg_p1_q;
      p2_d[tail_q] = mem_rdata;
      pc_d[tail_q] = stg_pc_q;
    end
  end

  // All fetch, assembly and buffer state; reset aborts any in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= W0;
      fetch_pc_q <= RESET_PC;
      iss_q      <= 2'd0;
      inflight_q <= 1'b0;
      raddr_q    <= 16'h0000;
      stg_op_q   <= 16'h0000;
      stg_p1_q   <= 16'h0000;
      stg_pc_q   <= 16'h0000;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      op_q       <= '{default: 16'h0000};
      p1_q       <= '{default: 16'h0000};
      p2_q       <= '{default: 16'h0000};
      pc_q       <= '{default: 16'h0000};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      iss_q      <= iss_d;
      inflight_q <= inflight_d;
      raddr_q    <= raddr_d;
      stg_op_q   <= stg_op_d;
      stg_p1_q   <= stg_p1_d;
      stg_pc_q   <= stg_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      op_q       <= op_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      pc_q       <= pc_d;
    end
  end
endmodule
